game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Upstream control stage for the pixel compositor. Debounces the four raw direction buttons and runs the start/play/dying/over game FSM.
- Latches per-pixel collision hits and drives game_state, halt and a one-cycle restart pulse.
- Consumers: the compositor, the movement, score and asteroid_move instances, and rng.
- Runs on the 25 MHz divided pixel clock.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synchronized button level must hold before it is accepted (10 ms at 25 MHz).
- DEATH_FRAMES, 60, frame ticks spent in DYING before OVER.
- AUTO_FRAMES, 600, frame ticks in OVER before automatic return to START (only with AUTO_RESTART_EN).

Ports:
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  4  raw buttons {down,up,right,left}, asynchronous
- debug  in  1  forced return to START from OVER, synchronous level
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- collide_px  in  1  dino layer overlaps obstacle/asteroid on the current pixel
- btn_level  out  4  debounced button levels
- btn_press  out  4  one-cycle rising-edge pulses of btn_level
- game_state  out  2  0=START, 1=PLAY (also shown during DYING), 2=OVER
- halt  out  1  freeze movement, score and asteroids
- dead  out  1  high in DYING and OVER; compositor selects the death sprite
- restart  out  1  one-cycle pulse that clears score/positions

Behaviour:
- Reset (rst_n low, asynchronous): FSM=START, all outputs 0, debounce counters 0, hit flag 0.
- Per button:
  - 2-FF synchronizer, then counter.
  - If sync != btn_level: count up; on reaching DEBOUNCE_CYCLES-1, btn_level <= sync and the counter clears.
  - If sync == btn_level: counter clears.
  - Latency from a clean edge to btn_level is 2+DEBOUNCE_CYCLES cycles.
- btn_press[i] = btn_level[i] & ~btn_level_q[i]; registered, one cycle wide.
- any_press = |btn_press; all_released = ~|btn_level.
- FSM internal states: START, PLAY, DYING, OVER.
- START
  - game_state=0, halt=1, dead=0.
  - any_press -> PLAY, restart pulses in the same cycle as the transition.
- PLAY
  - game_state=1, halt=0.
  - Hit flag sets on any cycle with collide_px=1.
  - On frame_tick with the flag set (including collide_px in that same cycle): clear the flag, frame counter <= 0, go to DYING.
  - Collisions are therefore committed only at frame boundaries, so a partially drawn frame never splits state.
- DYING
  - game_state=1, halt=1, dead=1.
  - Counts frame_tick; on reaching DEATH_FRAMES-1 -> OVER.
  - Button presses are ignored.
- OVER
  - game_state=2, halt=1, dead=1.
  - Restart is armed only after all_released has been seen once in OVER.
  - An armed any_press -> START with restart pulse.
  - debug=1 -> START with restart pulse, regardless of the arm.
  - If debug and an armed press occur together: a single transition and a single pulse.
- collide_px is ignored outside PLAY. The hit flag is cleared on every entry to PLAY.
- frame_tick and a button press in the same cycle: the FSM evaluates its current state only, with at most one transition per cycle.
- Counters saturate. The frame counter is $clog2(max(DEATH_FRAMES,AUTO_FRAMES))+1 bits and clears on every state entry.
- rst_n asserted mid-DYING or mid-OVER: immediate START, no restart pulse.

Optional Feature:
- Macro GAME_CTRL_AUTO_RESTART_EN.
- Defined: OVER counts frame_tick; at AUTO_FRAMES-1 -> START with a restart pulse. A button or debug exit earlier takes precedence.
- Undefined: OVER waits indefinitely for a button press or debug. The AUTO_FRAMES parameter is accepted but unused.

Decomposition:
- Package game_pkg holds:
  - the state enum (START=2'd0, PLAY=2'd1, OVER=2'd2, DYING=2'd3);
  - the game_state encodings GS_START/GS_PLAY/GS_OVER;
  - the button index constants BTN_LEFT=0..BTN_DOWN=3.
- One sub-module, btn_debounce (synchronizer plus counter plus level register, parameter DEBOUNCE_CYCLES), instantiated 4x.
- The FSM lives in game_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, DEATH_FRAMES=3, AUTO_FRAMES=5):
- Bounce: btn_raw[0] toggles 1,0,1 at 2-cycle spacing, then holds 1 -> btn_level[0] rises exactly 6 cycles after the final edge; one btn_press pulse; no pulse during the bounce.
- Start: in START, press up -> game_state 0->1, restart=1 for exactly 1 cycle, halt 1->0.
- Collision: in PLAY, collide_px=1 for 1 cycle mid-frame -> no change until frame_tick, then halt=1 and dead=1. After 3 more frame_ticks -> game_state=2.
- Re-arm: enter OVER with the button still held; release and re-press in 1 cycle -> no exit until all_released is seen, then the press gives START plus one restart pulse. debug=1 in OVER gives an immediate START.
- Reset: rst_n low in DYING, during a debounce count -> all outputs 0 asynchronously, state START, no restart pulse after release.
- Auto restart (macro defined): idle in OVER for 5 frame_ticks -> START with restart pulse. With the macro undefined, still OVER after 20 ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game control stage: FSM states,
// game_state encodings and button bit positions within btn_raw/btn_level.
package game_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2,
        DYING = 2'd3
    } state_t;

    localparam logic [1:0] GS_START = 2'd0;
    localparam logic [1:0] GS_PLAY  = 2'd1;
    localparam logic [1:0] GS_OVER  = 2'd2;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, then a hold counter that only
// accepts the synchronized level after it has been stable for DEBOUNCE_CYCLES.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the sync chain relies on it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Button debouncing and the START/PLAY/DYING/OVER game FSM for the compositor.
// Define GAME_CTRL_AUTO_RESTART_EN to leave OVER automatically after AUTO_FRAMES ticks.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEATH_FRAMES    = 60,
    parameter int AUTO_FRAMES     = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       debug,
    input  logic       frame_tick,
    input  logic       collide_px,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [1:0] game_state,
    output logic       halt,
    output logic       dead,
    output logic       restart
);

    localparam int FW = $clog2(max_int(DEATH_FRAMES, AUTO_FRAMES)) + 1;
    localparam logic [FW-1:0] DEATH_LAST = FW'(DEATH_FRAMES - 1);
`ifdef GAME_CTRL_AUTO_RESTART_EN
    localparam logic [FW-1:0] AUTO_LAST = FW'(AUTO_FRAMES - 1);
`endif

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i])
        );
    end

    logic [3:0] btn_level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level_q <= '0;
            btn_press   <= '0;
        end else begin
            btn_level_q <= btn_level;
            btn_press   <= btn_level & ~btn_level_q;
        end
    end

    logic any_press;
    logic all_released;
    assign any_press    = |btn_press;
    assign all_released = ~|btn_level;

    state_t        state, state_next;
    logic [FW-1:0] frame_cnt, frame_cnt_next, frame_inc;
    logic          hit, hit_next;
    logic          armed, armed_next;
    logic [1:0]    game_state_next;
    logic          halt_next, dead_next, restart_next;

    assign frame_inc = (&frame_cnt) ? frame_cnt : frame_cnt + FW'(1);

    // NOTE: every signal written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        hit_next       = hit;
        armed_next     = armed;
        restart_next   = 1'b0;

        case (state)
            START: begin
                if (any_press) begin
                    state_next   = PLAY;
                    restart_next = 1'b1;
                end
            end
            PLAY: begin
                // Hits are only committed on frame boundaries.
                if (frame_tick && (hit || collide_px)) begin
                    state_next = DYING;
                end else if (collide_px) begin
                    hit_next = 1'b1;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (frame_cnt == DEATH_LAST) state_next = OVER;
                    else                         frame_cnt_next = frame_inc;
                end
            end
            OVER: begin
                if (all_released) armed_next = 1'b1;
                if (debug || (armed && any_press)) begin
                    state_next   = START;
                    restart_next = 1'b1;
                end
`ifdef GAME_CTRL_AUTO_RESTART_EN
                else if (frame_tick) begin
                    if (frame_cnt == AUTO_LAST) begin
                        state_next   = START;
                        restart_next = 1'b1;
                    end else begin
                        frame_cnt_next = frame_inc;
                    end
                end
`endif
            end
            default: state_next = START;
        endcase

        // Per-state bookkeeping starts fresh on every entry.
        if (state_next != state) begin
            frame_cnt_next = '0;
            hit_next       = 1'b0;
            armed_next     = 1'b0;
        end

        case (state_next)
            PLAY:    begin game_state_next = GS_PLAY;  halt_next = 1'b0; dead_next = 1'b0; end
            DYING:   begin game_state_next = GS_PLAY;  halt_next = 1'b1; dead_next = 1'b1; end
            OVER:    begin game_state_next = GS_OVER;  halt_next = 1'b1; dead_next = 1'b1; end
            default: begin game_state_next = GS_START; halt_next = 1'b1; dead_next = 1'b0; end
        endcase
    end

    // Outputs are registered from the next state, so they read 0 under reset
    // and line up with the cycle in which the new state becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= START;
            frame_cnt  <= '0;
            hit        <= 1'b0;
            armed      <= 1'b0;
            game_state <= GS_START;
            halt       <= 1'b0;
            dead       <= 1'b0;
            restart    <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            hit        <= hit_next;
            armed      <= armed_next;
            game_state <= game_state_next;
            halt       <= halt_next;
            dead       <= dead_next;
            restart    <= restart_next;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with short debounce/frame parameters.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int DEB = 4;
    localparam int DF  = 3;
    localparam int AF  = 5;

    logic       clk, rst_n;
    logic [3:0] btn_raw;
    logic       debug, frame_tick, collide_px;
    logic [3:0] btn_level, btn_press;
    logic [1:0] game_state;
    logic       halt, dead, restart;

    game_ctrl #(.DEBOUNCE_CYCLES(DEB), .DEATH_FRAMES(DF), .AUTO_FRAMES(AF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .debug      (debug),
        .frame_tick (frame_tick),
        .collide_px (collide_px),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .game_state (game_state),
        .halt       (halt),
        .dead       (dead),
        .restart    (restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int restart_cnt = 0;
    int press_cnt = 0;

    always @(negedge clk) begin
        if (restart) restart_cnt++;
        press_cnt += $countones(btn_press);
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got %0h expected none", act);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, act, e.val);
        end
    endtask

    function automatic logic [11:0] outs();
        return {btn_level, btn_press, game_state, halt, dead, restart};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gs(input logic [1:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && game_state !== target; i++) step();
        push_exp(tag, target);
        pop_cmp(game_state);
    endtask

    task automatic wait_level(input int idx, input logic val, input int budget, input string tag);
        for (int i = 0; i < budget && btn_level[idx] !== val; i++) step();
        push_exp(tag, val);
        pop_cmp(btn_level[idx]);
    endtask

    task automatic press_release(input int idx);
        btn_raw[idx] = 1'b1;
        wait_level(idx, 1'b1, 20, "press_level_up");
        btn_raw[idx] = 1'b0;
        wait_level(idx, 1'b0, 20, "press_level_down");
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(2);
    endtask

    task automatic apply_reset();
        btn_raw = '0; debug = 0; frame_tick = 0; collide_px = 0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
    endtask

    task automatic die_to_over();
        collide_px = 1'b1;
        frame_tick = 1'b1;
        step();
        collide_px = 1'b0;
        frame_tick = 1'b0;
        push_exp("same_cycle_hit_dead", 1);
        pop_cmp(dead);
        repeat (DF) pulse_tick();
        push_exp("over_outs", {GS_OVER, 1'b1, 1'b1});
        pop_cmp({game_state, halt, dead});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rise;
        int rc0;
        int pc0;

        btn_raw = '0; debug = 0; frame_tick = 0; collide_px = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        push_exp("reset_outs", 0);
        pop_cmp(outs());
        step(2);
        rst_n = 1'b1;
        step();
        push_exp("start_outs", {GS_START, 1'b1, 1'b0});
        pop_cmp({game_state, halt, dead});

        // Bounce on LEFT: 1,0,1 at 2-cycle spacing, then hold.
        pc0 = press_cnt;
        btn_raw[BTN_LEFT] = 1'b1; step(2);
        btn_raw[BTN_LEFT] = 1'b0; step(2);
        push_exp("bounce_no_level", 0);
        pop_cmp(btn_level[BTN_LEFT]);
        push_exp("bounce_no_press", pc0);
        pop_cmp(press_cnt);
        btn_raw[BTN_LEFT] = 1'b1;
        rise = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (btn_level[BTN_LEFT] && rise < 0) rise = k;
        end
        push_exp("bounce_latency", 6);
        pop_cmp(rise);
        push_exp("bounce_one_press", pc0 + 1);
        pop_cmp(press_cnt);

        // Start via UP; a collision seen in START must not carry into PLAY.
        apply_reset();
        collide_px = 1'b1; step(); collide_px = 1'b0;
        push_exp("pre_start_halt", {GS_START, 1'b1, 1'b0});
        pop_cmp({game_state, halt, dead});
        rc0 = restart_cnt;
        btn_raw[BTN_UP] = 1'b1;
        wait_gs(GS_PLAY, 20, "start_to_play");
        push_exp("start_restart_high", 1);
        pop_cmp(restart);
        push_exp("start_halt_low", 0);
        pop_cmp(halt);
        step();
        push_exp("start_restart_one_cycle", 0);
        pop_cmp(restart);
        btn_raw[BTN_UP] = 1'b0;
        wait_level(BTN_UP, 1'b0, 20, "up_release");
        push_exp("start_one_restart", rc0 + 1);
        pop_cmp(restart_cnt);

        // Collision deferred to frame boundary, then DYING -> OVER.
        pulse_tick();
        push_exp("no_stale_hit", {GS_PLAY, 1'b0, 1'b0});
        pop_cmp({game_state, halt, dead});
        collide_px = 1'b1; step(); collide_px = 1'b0;
        step(3);
        push_exp("hit_deferred", {GS_PLAY, 1'b0, 1'b0});
        pop_cmp({game_state, halt, dead});
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        push_exp("dying_outs", {GS_PLAY, 1'b1, 1'b1});
        pop_cmp({game_state, halt, dead});
        btn_raw[BTN_RIGHT] = 1'b1;
        wait_level(BTN_RIGHT, 1'b1, 20, "right_held");
        step(2);
        push_exp("dying_ignores_press", {GS_PLAY, 1'b1, 1'b1});
        pop_cmp({game_state, halt, dead});
        pulse_tick();
        pulse_tick();
        push_exp("dying_after_2_ticks", GS_PLAY);
        pop_cmp(game_state);
        pulse_tick();
        push_exp("over_after_3_ticks", {GS_OVER, 1'b1, 1'b1});
        pop_cmp({game_state, halt, dead});

        // Re-arm: RIGHT held on entry, 1-cycle release is filtered.
        btn_raw[BTN_RIGHT] = 1'b0; step();
        btn_raw[BTN_RIGHT] = 1'b1; step(12);
        push_exp("glitch_filtered", 1);
        pop_cmp(btn_level[BTN_RIGHT]);
        push_exp("no_exit_unarmed", GS_OVER);
        pop_cmp(game_state);
        press_release(BTN_UP);
        step(2);
        push_exp("press_while_held_ignored", GS_OVER);
        pop_cmp(game_state);
        btn_raw[BTN_RIGHT] = 1'b0;
        wait_level(BTN_RIGHT, 1'b0, 20, "right_release");
        step(2);
        rc0 = restart_cnt;
        btn_raw[BTN_UP] = 1'b1;
        wait_gs(GS_START, 20, "armed_exit");
        push_exp("armed_exit_restart", 1);
        pop_cmp(restart);
        btn_raw[BTN_UP] = 1'b0;
        wait_level(BTN_UP, 1'b0, 20, "up_release2");
        push_exp("armed_exit_one_restart", rc0 + 1);
        pop_cmp(restart_cnt);

        // Debug exit from OVER.
        press_release(BTN_LEFT);
        wait_gs(GS_PLAY, 5, "play_again");
        die_to_over();
        rc0 = restart_cnt;
        debug = 1'b1; step(); debug = 1'b0;
        push_exp("debug_exit_state", GS_START);
        pop_cmp(game_state);
        push_exp("debug_exit_restart", 1);
        pop_cmp(restart);
        step(3);
        push_exp("debug_one_restart", rc0 + 1);
        pop_cmp(restart_cnt);

        // Idle in OVER: automatic exit only with the macro defined.
        press_release(BTN_LEFT);
        wait_gs(GS_PLAY, 5, "play_third");
        die_to_over();
        rc0 = restart_cnt;
`ifdef GAME_CTRL_AUTO_RESTART_EN
        repeat (AF - 1) pulse_tick();
        push_exp("auto_not_yet", GS_OVER);
        pop_cmp(game_state);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        push_exp("auto_exit_state", GS_START);
        pop_cmp(game_state);
        push_exp("auto_exit_restart", 1);
        pop_cmp(restart);
`else
        repeat (20) pulse_tick();
        push_exp("no_auto_still_over", GS_OVER);
        pop_cmp(game_state);
        push_exp("no_auto_no_restart", rc0);
        pop_cmp(restart_cnt);
        debug = 1'b1; step(); debug = 1'b0;
`endif

        // Asynchronous reset in DYING with a debounce count in progress.
        step(2);
        press_release(BTN_LEFT);
        wait_gs(GS_PLAY, 5, "play_fourth");
        collide_px = 1'b1; frame_tick = 1'b1; step();
        collide_px = 1'b0; frame_tick = 1'b0;
        btn_raw[BTN_DOWN] = 1'b1;
        step(3);
        rc0 = restart_cnt;
        #2 rst_n = 1'b0;
        btn_raw = '0;
        #1;
        push_exp("async_reset_outs", 0);
        pop_cmp(outs());
        step(2);
        rst_n = 1'b1;
        step(8);
        push_exp("post_reset_start", {GS_START, 1'b1, 1'b0});
        pop_cmp({game_state, halt, dead});
        push_exp("post_reset_no_restart", rc0);
        pop_cmp(restart_cnt);
        push_exp("post_reset_levels", 0);
        pop_cmp(btn_level);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
